// File: rtl/flash_clkrst_seq.sv
// Reset-release sequencer for the flash clock/reset buffer column: holds all far-end
// resets, releases them one by one in index order, then waits for the returned acks.
module flash_clkrst_seq #(
    parameter int NUM_RST   = 12,
    parameter int ACK_W     = 3,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_GAP = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               sw_rst_req_i,
    input  logic [ACK_W-1:0]   ack_i,
    output logic [NUM_RST-1:0] rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int MAX_HG  = (HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP;
    localparam int MAX_CYC = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);

    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_RELEASE  = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_ERROR    = 3'd4;

    logic [ACK_W-1:0]   r_ack_p0;
    logic [ACK_W-1:0]   r_ack_p1;
    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_RST-1:0] r_rst;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_ack_ok;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_clr;

    // Stage p0/p1: two-flop synchronizer for the asynchronous ack lines
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack_p0 <= '0;
            r_ack_p1 <= '0;
        end else begin
            r_ack_p0 <= ack_i;
            r_ack_p1 <= r_ack_p0;
        end
    end

    assign w_ack_ok = &r_ack_p1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_clr       = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    w_clr     = 1'b1;
                    // index saturates at the last line so it never wraps
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_WAIT_ACK;
                    end else begin
                        w_idx_nxt = r_idx + IDX_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_ACK: begin
                // ack is tested first so an ack on the final cycle beats the timeout
                if (w_ack_ok) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_DONE: begin
                if (!w_ack_ok) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
            default: begin
                w_state_nxt = S_ERROR;
            end
        endcase
    end

    // Stage boundary: state, counters and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || sw_rst_req_i) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            if (w_clr) begin
                r_rst[r_idx] <= 1'b0;
            end
            r_busy <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_RELEASE) ||
                      (w_state_nxt == S_WAIT_ACK);
            r_done <= (w_state_nxt == S_DONE);
            r_err  <= (w_state_nxt == S_ERROR);
        end
    end

    assign rst_o  = r_rst;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign err_o  = r_err;

endmodule

// File: tb/tb_flash_clkrst_seq.sv
// Directed bench for flash_clkrst_seq at default parameters; edge numbers follow
// the E1 = first rising edge with wb_rst_i low convention.
module tb_flash_clkrst_seq;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        sw_rst_req_i;
    logic [2:0]  ack_i;
    logic [11:0] rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;
    int ec    = 0;

    flash_clkrst_seq dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .sw_rst_req_i (sw_rst_req_i),
        .ack_i        (ack_i),
        .rst_o        (rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Edge counter: ec == n between edge En and E(n+1)
    always @(posedge wb_clk_i) begin
        if (wb_rst_i) ec <= 0;
        else          ec <= ec + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ec(input int n);
        int g;
        g = 0;
        while (ec != n && g < 5000) begin
            @(negedge wb_clk_i);
            g++;
        end
        if (ec != n) chk("wait_ec", ec, n);
    endtask

    task automatic do_reset(input logic sw_too);
        @(negedge wb_clk_i);
        wb_rst_i     = 1'b1;
        sw_rst_req_i = sw_too;
        @(negedge wb_clk_i);
        sw_rst_req_i = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        chk("rst_rst_o", rst_o, 12'hFFF);
        chk("rst_busy", busy_o, 1'b1);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        wb_rst_i = 1'b0;
    endtask

    initial begin
        wb_rst_i     = 1'b1;
        sw_rst_req_i = 1'b0;
        ack_i        = 3'b111;

        // Normal release with acks present
        do_reset(1'b0);
        for (int k = 0; k < 12; k++) begin
            wait_ec(19 + 4 * k);
            chk("pre_release_bit", rst_o[k], 1'b1);
            wait_ec(20 + 4 * k);
            chk("release_vec", rst_o, (12'hFFF << (k + 1)) & 12'hFFF);
        end
        chk("e64_busy", busy_o, 1'b1);
        chk("e64_done", done_o, 1'b0);
        wait_ec(65);
        chk("e65_done", done_o, 1'b1);
        chk("e65_busy", busy_o, 1'b0);
        chk("e65_err", err_o, 1'b0);

        // Ack timeout
        ack_i = 3'b011;
        do_reset(1'b0);
        wait_ec(1086);
        chk("to_e1086_err", err_o, 1'b0);
        chk("to_e1086_busy", busy_o, 1'b1);
        wait_ec(1087);
        chk("to_e1087_err", err_o, 1'b1);
        chk("to_e1087_busy", busy_o, 1'b0);
        chk("to_e1087_done", done_o, 1'b0);
        chk("to_e1087_rst", rst_o, 12'h000);

        // Ack arriving on the last WAIT_ACK cycle wins over the timeout
        ack_i = 3'b011;
        do_reset(1'b0);
        wait_ec(1084);
        ack_i = 3'b111;
        wait_ec(1086);
        chk("late_e1086_done", done_o, 1'b0);
        chk("late_e1086_busy", busy_o, 1'b1);
        wait_ec(1087);
        chk("late_e1087_done", done_o, 1'b1);
        chk("late_e1087_err", err_o, 1'b0);
        wait_ec(1090);
        chk("late_e1090_err", err_o, 1'b0);

        // Software request mid-RELEASE
        ack_i = 3'b111;
        do_reset(1'b0);
        wait_ec(39);
        chk("sw_e39_rst", rst_o, 12'hFE0);
        sw_rst_req_i = 1'b1;
        wait_ec(40);
        sw_rst_req_i = 1'b0;
        chk("sw_e40_rst", rst_o, 12'hFFF);
        chk("sw_e40_busy", busy_o, 1'b1);
        wait_ec(59);
        chk("sw_e59_rst", rst_o, 12'hFFF);
        wait_ec(60);
        chk("sw_e60_rst", rst_o, 12'hFFE);
        wait_ec(104);
        chk("sw_e104_rst", rst_o, 12'h000);
        wait_ec(105);
        chk("sw_e105_done", done_o, 1'b1);

        // Ack glitch in DONE, then software recovery
        wait_ec(110);
        ack_i = 3'b101;
        wait_ec(111);
        ack_i = 3'b111;
        wait_ec(112);
        chk("glitch_e112_done", done_o, 1'b1);
        chk("glitch_e112_err", err_o, 1'b0);
        wait_ec(113);
        chk("glitch_e113_err", err_o, 1'b1);
        chk("glitch_e113_done", done_o, 1'b0);
        chk("glitch_e113_busy", busy_o, 1'b0);
        chk("glitch_e113_rst", rst_o, 12'h000);
        wait_ec(116);
        chk("glitch_sticky_err", err_o, 1'b1);
        wait_ec(119);
        sw_rst_req_i = 1'b1;
        wait_ec(120);
        sw_rst_req_i = 1'b0;
        chk("recov_err", err_o, 1'b0);
        chk("recov_busy", busy_o, 1'b1);
        chk("recov_rst", rst_o, 12'hFFF);
        wait_ec(140);
        chk("recov_e140_rst", rst_o, 12'hFFE);

        // wb_rst_i and sw_rst_req_i together, mid-sequence
        wait_ec(150);
        ack_i = 3'b000;
        do_reset(1'b1);
        ack_i = 3'b111;
        wait_ec(19);
        chk("both_e19_rst", rst_o, 12'hFFF);
        wait_ec(20);
        chk("both_e20_rst", rst_o, 12'hFFE);
        wait_ec(64);
        chk("both_e64_done", done_o, 1'b0);
        wait_ec(65);
        chk("both_e65_done", done_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
